// File: rtl/axi_read_initiator.sv
// AXI read-burst initiator: one address phase, then counted data beats.
// Optional rvalid timeout under AXI_READ_INITIATOR_TIMEOUT_EN.
module axi_read_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  output logic       arvalid,
  output logic [7:0] arlen,
  input  logic       arready,
  input  logic       rvalid,
  input  logic       rlast,
  output logic       rready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] beats,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] arlen_q;
  logic [8:0] beats_q;
  logic       err_q;
  logic       take;
  logic       beat;
  logic       at_end;
  logic       to_hit;

  assign take   = (state == IDLE) && start;
  assign beat   = (state == DATA) && rvalid;
  assign at_end = (beats_q == {1'b0, arlen_q});

`ifdef AXI_READ_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          timeout_q;

  assign to_hit = (state == DATA) && !rvalid &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Consecutive rvalid-free DATA cycles; any beat or other state clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if ((state == DATA) && !rvalid) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (take) begin
      timeout_q <= 1'b0;
    end else if (to_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: DATA ends on rlast, on the last expected beat, or timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)   state_nxt = ADDR;
      ADDR: if (arready) state_nxt = DATA;
      DATA: begin
        if (beat && (rlast || at_end)) begin
          state_nxt = DONE;
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: length capture, beat count, length-mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arlen_q <= 8'd0;
      beats_q <= 9'd0;
      err_q   <= 1'b0;
    end else if (take) begin
      arlen_q <= len;
      beats_q <= 9'd0;
      err_q   <= 1'b0;
    end else if (beat) begin
      beats_q <= beats_q + 9'd1;
      if (rlast || at_end) begin
        err_q <= !(rlast && at_end);
      end
    end
  end

  assign arvalid = (state == ADDR);
  assign rready  = (state == DATA);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign arlen   = arlen_q;
  assign beats   = beats_q;
  assign err     = err_q;

endmodule

// File: tb/tb_axi_read_initiator.sv
// Directed bench for axi_read_initiator; done-pulse scoreboard.
// Timeout case runs when AXI_READ_INITIATOR_TIMEOUT_EN is defined.
module tb_axi_read_initiator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       arvalid;
  logic [7:0] arlen;
  logic       arready;
  logic       rvalid;
  logic       rlast;
  logic       rready;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] beats;
  logic       timeout;

  axi_read_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len    (len),
    .arvalid(arvalid),
    .arlen  (arlen),
    .arready(arready),
    .rvalid (rvalid),
    .rlast  (rlast),
    .rready (rready),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .beats  (beats),
    .timeout(timeout)
  );

  typedef struct {
    int b;
    int e;
    int t;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   av_cycles = 0;
  int   done_cnt  = 0;
  int   exp_arlen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: arlen stability during ADDR, result check on each done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (arvalid) begin
        av_cycles++;
        chk("arlen_stable", int'(arlen), exp_arlen);
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("beats", int'(beats), e.b);
          chk("err", int'(err), e.e);
          chk("timeout", int'(timeout), e.t);
        end
      end
    end
  end

  task automatic burst(input int l, input int ardly, input int last_at,
                       input int offered, input int eb, input int ee,
                       input int et, input bit poke);
    int d0;
    int n;
    sb.push_back('{eb, ee, et});
    exp_arlen = l;
    av_cycles = 0;
    d0 = done_cnt;
    len = 8'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    len = 8'd0;
    repeat (ardly) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < offered; i++) begin
      rvalid = 1'b1;
      rlast = (i == last_at);
      tick();
      if (last_at < 0 && i == l) begin
        @(negedge clk);
        chk("rready_drop", int'(rready), 0);
      end
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    if (poke) begin
      len = 8'(l ^ 8'hA5);
      start = 1'b1;
      tick();
      start = 1'b0;
      len = 8'd0;
      chk("start_ignored", int'(arlen), l);
    end
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk("idle_reached", int'(busy), 0);
    chk("arvalid_cycles", av_cycles, ardly + 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("beats_hold", int'(beats), eb);
    chk("err_hold", int'(err), ee);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    #3;
    chk("rst_arvalid", int'(arvalid), 0);
    chk("rst_rready", int'(rready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_arlen", int'(arlen), 0);
    chk("rst_beats", int'(beats), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    burst(7, 0, 7, 8, 8, 0, 0, 1'b0);
    burst(3, 5, 3, 4, 4, 0, 0, 1'b0);
    burst(3, 0, 1, 2, 2, 1, 0, 1'b0);
    burst(3, 0, -1, 6, 4, 1, 0, 1'b0);
    burst(0, 0, 0, 1, 1, 0, 0, 1'b1);
    burst(255, 2, 255, 256, 256, 0, 0, 1'b0);

    d0 = done_cnt;
    exp_arlen = 7;
    len = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rready", int'(rready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_beats", int'(beats), 0);
    chk("mid_rst_arlen", int'(arlen), 0);
    chk("mid_rst_done", int'(done), 0);
    rvalid = 1'b0;
    tick();
    tick();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", int'(busy), 0);
    burst(1, 0, 1, 2, 2, 0, 0, 1'b0);

`ifdef AXI_READ_INITIATOR_TIMEOUT_EN
    burst(3, 1, -1, 0, 0, 0, 1, 1'b1);
    chk("timeout_hold", int'(timeout), 1);
`endif

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_read_initiator.md
AXI_READ_INITIATOR -- requirements
Module: axi_read_initiator

Interface
REQ-001 The parameter SHALL be: TIMEOUT_CYCLES, default 16, the number of consecutive DATA-state cycles without rvalid before a timeout fires (used only under AXI_READ_INITIATOR_TIMEOUT_EN).
REQ-002 The port list SHALL be as follows, one port per line:
- clk  input  1  single clock; all flops on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  single-cycle request to begin one burst; sampled in IDLE only.
- len  input  8  burst length minus one (AXI arlen encoding); sampled with start.
- arvalid  output  1  read-address valid.
- arlen  output  8  read-address burst length.
- arready  input  1  read-address ready from target.
- rvalid  input  1  read-data valid from target.
- rlast  input  1  read-data last beat.
- rready  output  1  read-data ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  rlast/length mismatch flag for the finished burst.
- beats  output  9  count of data beats accepted in the current or last burst.
- timeout  output  1  rvalid timeout flag (tied 0 without the macro).

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, ADDR, DATA, DONE; all outputs SHALL be registered or decoded from the state register only.
REQ-004 In IDLE with start=1, the block SHALL capture len into arlen, clear beats, err and timeout, and enter ADDR on the next edge.
REQ-005 In ADDR, arvalid SHALL be 1 and arlen SHALL remain stable until arready=1 is sampled; on that edge the FSM SHALL enter DATA.
REQ-006 arvalid SHALL be 0 in every state other than ADDR; arready in other states SHALL be ignored.
REQ-007 In DATA, rready SHALL be 1; in every other state rready SHALL be 0.
REQ-008 Each edge with rvalid=1 and rready=1 SHALL be one beat and SHALL increment beats by 1; beats is 9 bits, so a 256-beat burst SHALL read 256 with no wrap-around.
REQ-009 On a beat with rlast=1, the FSM SHALL enter DONE; err SHALL be set if the beat's zero-based index is not equal to arlen (early rlast).
REQ-010 On the beat whose index equals arlen with rlast=0, the FSM SHALL set err and enter DONE; further target beats SHALL not be accepted.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err, beats and timeout SHALL hold their values until the next accepted start.
REQ-012 start SHALL be ignored while busy=1, including in DONE; a start arriving in the same cycle as DONE SHALL be lost.
REQ-013 arlen=0 SHALL give a single-beat burst; rlast=1 on beat 0 SHALL complete the burst without error.

Reset
REQ-014 When rst_n=0, the state SHALL be IDLE and arvalid, rready, busy, done, err, timeout SHALL be 0, arlen SHALL be 0 and beats SHALL be 0, asynchronously.
REQ-015 If reset asserts mid-burst, the burst SHALL be abandoned with no done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-016 With AXI_READ_INITIATOR_TIMEOUT_EN defined, a counter SHALL count consecutive DATA cycles with rvalid=0 and clear on any rvalid=1.
REQ-017 When that counter reaches TIMEOUT_CYCLES, the block SHALL set timeout=1 and enter DONE, and done SHALL pulse.
REQ-018 Without AXI_READ_INITIATOR_TIMEOUT_EN, there SHALL be no counter, timeout SHALL be constant 0, and DATA SHALL wait indefinitely.

Verification
REQ-019 Reset, then start with len=7, arready=1 immediately, and 8 beats with rlast on beat 7 -> arvalid high for exactly 1 cycle, beats=8, done pulses once, err=0.
REQ-020 Hold arready=0 for 5 cycles after start, with len=3 -> arvalid and arlen=3 stable for 6 cycles, then 4 beats complete with err=0.
REQ-021 With len=3, rlast on beat 1 -> done pulses, beats=2, err=1; with len=3 and no rlast on beat 3 -> beats=4, err=1, rready drops the cycle after.
REQ-022 With len=0 and a single beat with rlast -> beats=1, err=0; with len=255 and rlast on the last beat -> beats=256, err=0.
REQ-023 Assert rst_n=0 after 2 beats of an 8-beat burst -> all outputs 0 immediately, no done pulse; a following start with len=1 completes normally.
REQ-024 With the macro defined and TIMEOUT_CYCLES=16, withhold rvalid in DATA -> timeout=1 and done pulse after 16 idle cycles; pulse start while busy -> ignored.
